reg_file_mp: RTL and testbench

//  Parametrised multi-port integer register file for the RV32 core, successor to the 1W/2R reg_file.

---
 rtl/reg_file_mp_pkg.sv | 12 +
 rtl/reg_file_rd_port.sv | 45 ++++
 rtl/reg_file_mp.sv | 103 ++++++++++
 tb/tb_reg_file_mp.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// rtl/reg_file_mp_pkg.sv - shared types and default constants for the multi-port register file
package reg_file_mp_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } rf_state_t;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

endpackage

// File: rtl/reg_file_rd_port.sv
// rtl/reg_file_rd_port.sv - one read port: write bypass, zero-register mux and output register
module reg_file_rd_port
    import reg_file_mp_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int AW       = 5,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_re,
    input  logic                ready,
    input  logic [AW-1:0]       rs,
    input  logic [XLEN-1:0]     mem_value,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic [XLEN-1:0]     read_data
);

    logic [XLEN-1:0] value;

    // Later write ports override earlier ones, matching the storage priority.
    always_comb begin
        value = mem_value;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == rs)) begin
                value = wr_data[j*XLEN +: XLEN];
            end
        end
        if ((ZERO_REG != 0) && (rs == '0)) begin
            value = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !ready) begin
            read_data <= '0;
        end else if (i_re) begin
            read_data <= value;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - NRD-read / NWR-write register file with bypass, hardwired x0 and clear sequencer
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_re,
    input  logic [NRD*AW-1:0]   i_rs,
    input  logic [NWR-1:0]      i_wr,
    input  logic [NWR*AW-1:0]   i_rd,
    input  logic [NWR*XLEN-1:0] i_write_data,
    output logic [NRD*XLEN-1:0] o_read_data,
    output logic                o_ready
);

    logic [XLEN-1:0] mem [NREGS];
    rf_state_t       state;
    logic [AW-1:0]   clr_idx;
    logic [NWR-1:0]  wr_eff;
    logic            port_ready;

    // A clear request in the same cycle as a user access cancels that access.
    assign port_ready = o_ready & ~i_clear;

    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            wr_eff[j] = port_ready & ~rst & i_wr[j]
                      & ~((ZERO_REG != 0) && (i_rd[j*AW +: AW] == '0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            o_ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_idx <= clr_idx + AW'(1);
                    if (clr_idx == AW'(NREGS - 1)) begin
                        state   <= ST_READY;
                        o_ready <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (i_clear) begin
                        state   <= ST_CLEAR;
                        clr_idx <= '0;
                        o_ready <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_idx <= '0;
                    o_ready <= 1'b0;
                end
            endcase
        end
    end

    // Ascending loop: the highest-index write port lands last and wins.
    always_ff @(posedge clk) begin
        if (!rst && (state == ST_CLEAR)) begin
            mem[clr_idx] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_eff[j]) begin
                    mem[i_rd[j*AW +: AW]] <= i_write_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        reg_file_rd_port #(
            .XLEN     (XLEN),
            .AW       (AW),
            .NWR      (NWR),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .clk       (clk),
            .rst       (rst),
            .i_re      (i_re),
            .ready     (port_ready),
            .rs        (i_rs[k*AW +: AW]),
            .mem_value (mem[i_rs[k*AW +: AW]]),
            .wr_en     (wr_eff),
            .wr_addr   (i_rd),
            .wr_data   (i_write_data),
            .read_data (o_read_data[k*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp against a behavioural model
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_clear;
    logic                i_re;
    logic [NRD*AW-1:0]   i_rs;
    logic [NWR-1:0]      i_wr;
    logic [NWR*AW-1:0]   i_rd;
    logic [NWR*XLEN-1:0] i_write_data;
    logic [NRD*XLEN-1:0] o_read_data;
    logic                o_ready;

    always #5 clk = ~clk;

    reg_file_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
    ) dut (
        .clk(clk), .rst(rst), .i_clear(i_clear), .i_re(i_re), .i_rs(i_rs),
        .i_wr(i_wr), .i_rd(i_rd), .i_write_data(i_write_data),
        .o_read_data(o_read_data), .o_ready(o_ready)
    );

    typedef struct {
        logic                rdy;
        logic [NRD*XLEN-1:0] d;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [XLEN-1:0]     mem_m [NREGS];
    bit                  ready_m  = 1'b0;
    int                  remain_m = 0;
    logic [NRD*XLEN-1:0] out_m    = '0;

    // Model: the file is "busy for NREGS cycles then all-zero"; reads see same-cycle writes.
    task automatic step();
        exp_t            e;
        logic [XLEN-1:0] nv [NREGS];
        bit              hit [NREGS];
        int              a;
        for (int r = 0; r < NREGS; r++) begin
            hit[r] = 1'b0;
            nv[r]  = '0;
        end
        if (rst) begin
            ready_m  = 1'b0;
            remain_m = NREGS;
            out_m    = '0;
            for (int r = 0; r < NREGS; r++) mem_m[r] = '0;
        end else if (!ready_m) begin
            remain_m = remain_m - 1;
            if (remain_m == 0) ready_m = 1'b1;
            out_m = '0;
        end else if (i_clear) begin
            ready_m  = 1'b0;
            remain_m = NREGS;
            out_m    = '0;
            for (int r = 0; r < NREGS; r++) mem_m[r] = '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                a = int'(i_rd[j*AW +: AW]);
                if (i_wr[j] && a != 0) begin
                    hit[a] = 1'b1;
                    nv[a]  = i_write_data[j*XLEN +: XLEN];
                end
            end
            if (i_re) begin
                for (int k = 0; k < NRD; k++) begin
                    a = int'(i_rs[k*AW +: AW]);
                    out_m[k*XLEN +: XLEN] = (a == 0) ? '0 : (hit[a] ? nv[a] : mem_m[a]);
                end
            end
            for (int r = 0; r < NREGS; r++) if (hit[r]) mem_m[r] = nv[r];
        end
        e.rdy = ready_m;
        e.d   = out_m;
        @(posedge clk);
        expq.push_back(e);
        cyc++;
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (o_ready !== e.rdy) begin
                    errors++;
                    $display("FAIL ready cyc %0d got %b exp %b", cyc, o_ready, e.rdy);
                end
                for (int k = 0; k < NRD; k++) begin
                    checks++;
                    if (o_read_data[k*XLEN +: XLEN] !== e.d[k*XLEN +: XLEN]) begin
                        errors++;
                        $display("FAIL rdata%0d cyc %0d got %h exp %h", k, cyc,
                                 o_read_data[k*XLEN +: XLEN], e.d[k*XLEN +: XLEN]);
                    end
                end
            end
        end
    end

    task automatic idle();
        rst = 1'b0; i_clear = 1'b0; i_re = 1'b0;
        i_wr = '0; i_rd = '0; i_write_data = '0; i_rs = '0;
    endtask

    task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        i_wr[j] = 1'b1;
        i_rd[j*AW +: AW] = a;
        i_write_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        i_re = 1'b1;
        i_rs = {a1, a0};
    endtask

    initial begin
        idle();
        // reset, full clear, then every entry reads zero
        rst = 1'b1; step(); step();
        rst = 1'b0;
        repeat (NREGS) step();
        for (int a = 1; a < NREGS; a++) begin
            idle(); set_rd(AW'(a), AW'(NREGS - a)); step();
        end
        // stored reads
        idle(); set_wr(0, 5, 32'hABCDEFFF); step();
        idle(); set_wr(0, 7, 32'hABCDADFF); step();
        idle(); set_rd(5, 7); step();
        idle(); step();
        // bypass and x0
        idle(); set_wr(0, 5, 32'h12345678); set_rd(5, 7); step();
        idle(); set_wr(0, 0, 32'hFFFFFFFF); set_rd(0, 5); step();
        idle(); set_rd(0, 0); step();
        // dual-port collision: port 1 wins
        idle(); set_wr(0, 9, 32'h11111111); set_wr(1, 9, 32'h22222222); set_rd(9, 9); step();
        idle(); set_rd(9, 5); step();
        idle(); set_wr(0, 9, 32'h33333333); i_rs = {AW'(1), AW'(2)}; step();
        idle(); step();
        idle(); set_rd(9, 9); step();
        // clear with a same-cycle write that must be dropped
        idle(); i_clear = 1'b1; set_wr(0, 3, 32'hDEADBEEF); set_rd(3, 9); step();
        for (int c = 0; c < NREGS; c++) begin
            idle(); set_wr(0, AW'(c), 32'hA5A5A5A5); set_rd(3, AW'(c)); step();
        end
        for (int a = 0; a < NREGS; a++) begin
            idle(); set_rd(AW'(a), 3); step();
        end
        // reset mid-clear restarts the full sequence
        idle(); rst = 1'b1; step();
        idle(); repeat (10) step();
        rst = 1'b1; step();
        idle(); repeat (NREGS + 2) step();
        // randomized traffic with occasional clear and reset
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst     = ($urandom_range(0, 399) == 0);
            i_clear = ($urandom_range(0, 99) == 0);
            i_re    = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < NWR; j++) begin
                i_wr[j] = $urandom_range(0, 1);
                i_rd[j*AW +: AW] = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
                i_write_data[j*XLEN +: XLEN] = $urandom;
            end
            for (int k = 0; k < NRD; k++) begin
                i_rs[k*AW +: AW] = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            end
            step();
        end
        idle();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
